// File: rtl/score_bcd_sched.sv
// score_bcd_sched
//   Binary-to-BCD converter shared by two score requesters. It arbitrates
//   between the current score (requester 0) and the high score (requester 1),
//   converts the granted value with a serial shift-add-3 (double-dabble)
//   datapath taking BIN_W cycles, and presents three BCD digits together with
//   a one-cycle valid strobe and the requester id.
//
//   Optional feature macro: SCORE_BCD_RR_EN
//     defined   : round-robin arbitration (a tie goes to the requester not
//                 granted last)
//     undefined : fixed priority (requester 0 wins a tie)
//
// Ports
//   clk                    system clock, rising edge
//   rst_n                  asynchronous active-low reset
//   req[1:0]               per-requester level request, held until ack
//   bin0, bin1 [BIN_W-1:0] requester values, stable while requested
//   ack[1:0]               one-hot one-cycle grant/capture pulse
//   busy                   high whenever a conversion is in flight
//   valid                  one-cycle pulse when the digit outputs update
//   id                     requester owning the digits on the outputs
//   hundreds, tens, ones   BCD result digits, held until the next result
module score_bcd_sched #(
    parameter int BIN_W = 8   // 1..9, result fits in three BCD digits
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [BIN_W-1:0] bin0,
    input  logic [BIN_W-1:0] bin1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             valid,
    output logic             id,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [BIN_W-1:0] sh;          // binary bits still to be shifted in
    logic [3:0]       wh, wt, wo;  // working digits
    logic [3:0]       cnt;         // remaining shift cycles minus one
    logic             pend_id;
    logic             win;         // requester 1 wins this contest

    // Add-3 correction applied before every shift.
    function automatic logic [3:0] adj3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    logic [11:0] adj;
    assign adj = {adj3(wh), adj3(wt), adj3(wo)};

`ifdef SCORE_BCD_RR_EN
    logic last;  // requester granted most recently

    // On a tie the requester that was not granted last wins.
    assign win = req[1] & (~req[0] | ~last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (state == S_IDLE && req != 2'b00)
            last <= win;
    end
`else
    assign win = req[1] & ~req[0];
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sh       <= '0;
            wh       <= '0;
            wt       <= '0;
            wo       <= '0;
            cnt      <= '0;
            pend_id  <= 1'b0;
            ack      <= 2'b00;
            valid    <= 1'b0;
            id       <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            ack   <= 2'b00;
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        sh      <= win ? bin1 : bin0;
                        wh      <= '0;
                        wt      <= '0;
                        wo      <= '0;
                        cnt     <= 4'(BIN_W - 1);
                        ack     <= win ? 2'b10 : 2'b01;
                        pend_id <= win;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The hundreds MSB falls off the top; it is always zero
                    // for BIN_W <= 9.
                    {wh, wt, wo, sh} <= {adj, sh} << 1;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0)
                        state <= S_DONE;
                end
                S_DONE: begin
                    hundreds <= wh;
                    tens     <= wt;
                    ones     <= wo;
                    id       <= pend_id;
                    valid    <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_sched.sv
// Testbench for score_bcd_sched: directed vectors, a transaction-level
// reference model compared every cycle, and literal spot checks.
module tb_score_bcd_sched;

    localparam int BIN_W = 8;
`ifdef SCORE_BCD_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [BIN_W-1:0] bin0 = '0;
    logic [BIN_W-1:0] bin1 = '0;
    logic [1:0]       ack;
    logic             busy, valid, id;
    logic [3:0]       hundreds, tens, ones;

    int vectors = 0;
    int miscompares = 0;

    score_bcd_sched #(.BIN_W(BIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bin0(bin0), .bin1(bin1),
        .ack(ack), .busy(busy), .valid(valid), .id(id),
        .hundreds(hundreds), .tens(tens), .ones(ones)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A conversion is a transaction: granted at some edge, result appears
    // BIN_W+1 edges later, and the engine is free again from the next edge.
    logic [1:0] e_ack = 2'b00;
    logic       e_busy = 1'b0, e_valid = 1'b0, e_id = 1'b0;
    logic [3:0] e_h = 4'd0, e_t = 4'd0, e_o = 4'd0;

    initial begin
        int  left;
        int  m_val;
        bit  m_id, active, last_m, w;
        active = 0; last_m = 1; left = 0; m_val = 0; m_id = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                active = 0; last_m = 1;
                e_ack = 2'b00; e_busy = 0; e_valid = 0; e_id = 0;
                e_h = 0; e_t = 0; e_o = 0;
            end else begin
                e_ack = 2'b00;
                e_valid = 0;
                if (active) begin
                    left--;
                    if (left == 0) begin
                        active  = 0;
                        e_valid = 1;
                        e_id    = m_id;
                        e_h     = 4'(m_val / 100);
                        e_t     = 4'((m_val / 10) % 10);
                        e_o     = 4'(m_val % 10);
                    end
                end else if (req != 2'b00) begin
                    if (req == 2'b11) w = RR ? !last_m : 1'b0;
                    else              w = req[1];
                    last_m = w;
                    m_id   = w;
                    m_val  = w ? int'(bin1) : int'(bin0);
                    e_ack  = w ? 2'b10 : 2'b01;
                    left   = BIN_W + 1;
                    active = 1;
                end
                e_busy = active;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        vectors++;
        if ({ack, busy, valid, id, hundreds, tens, ones} !==
            {e_ack, e_busy, e_valid, e_id, e_h, e_t, e_o}) begin
            miscompares++;
            $display("FAIL cycle_cmp t=%0t got ack=%b busy=%b valid=%b id=%b bcd=%h%h%h want ack=%b busy=%b valid=%b id=%b bcd=%h%h%h",
                     $time, ack, busy, valid, id, hundreds, tens, ones,
                     e_ack, e_busy, e_valid, e_id, e_h, e_t, e_o);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Request a conversion on one requester; release req inside the ack
    // cycle. lat = edges from the request edge to the edge raising valid.
    task automatic do_conv(input int idx, input int val,
                           output logic [11:0] bcd, output int rid,
                           output int lat);
        bit got_ack, got_val;
        @(posedge clk); #1;
        if (idx == 0) bin0 = BIN_W'(val); else bin1 = BIN_W'(val);
        req[idx] = 1'b1;
        got_ack = 0; got_val = 0; lat = 0; bcd = '0; rid = 0;
        for (int k = 0; k < 40 && !got_val; k++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (ack[idx]) begin got_ack = 1; req[idx] = 1'b0; end
            if (valid) begin
                got_val = 1;
                bcd = {hundreds, tens, ones};
                rid = int'(id);
            end
        end
        req[idx] = 1'b0;
        if (!got_ack || !got_val) begin
            miscompares++;
            $display("FAIL conv_timeout val=%0d ack_seen=%0d valid_seen=%0d want both", val, got_ack, got_val);
        end
    endtask

    function automatic logic [11:0] dec3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        logic [11:0] bcd;
        int rid, lat, n_ack, vcyc, a1cyc, cyc, nval;
        int acyc[4];
        logic [1:0] aval[4];
        bit got;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", int'({ack, busy, valid, id, hundreds, tens, ones}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 255 on requester 0
        do_conv(0, 255, bcd, rid, lat);
        chk("r0_255_bcd", int'(bcd), 'h255);
        chk("r0_255_id", rid, 0);
        chk("r0_255_latency", lat, BIN_W + 2);
        @(negedge clk);
        chk("busy_low_after_valid", int'(busy), 0);

        // 99 then 0 on requester 1
        do_conv(1, 99, bcd, rid, lat);
        chk("r1_99_bcd", int'(bcd), 'h099);
        chk("r1_99_id", rid, 1);
        do_conv(1, 0, bcd, rid, lat);
        chk("r1_0_bcd", int'(bcd), 'h000);
        chk("r1_0_id", rid, 1);

        // Both requesters held high; last grant so far went to requester 1.
        @(posedge clk); #1;
        bin0 = 8'd17; bin1 = 8'd230; req = 2'b11;
        n_ack = 0; cyc = 0;
        for (int k = 0; k < 80 && n_ack < 4; k++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (ack != 2'b00) begin
                aval[n_ack] = ack; acyc[n_ack] = cyc; n_ack++;
                if (n_ack == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        chk("tie_ack_count", n_ack, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_ack%0d", i), int'(aval[i]),
                RR ? ((i % 2 == 0) ? 1 : 2) : 1);
        // Grant edges sit BIN_W+2 edges apart (BIN_W+3 cycles inclusive).
        for (int i = 0; i < 3; i++)
            chk($sformatf("tie_spacing%0d", i), acyc[i+1] - acyc[i], BIN_W + 2);
        repeat (BIN_W + 4) @(negedge clk);

        // Requester 1 asks mid-conversion of requester 0
        @(posedge clk); #1;
        bin0 = 8'd37; req[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ack[0]) got = 1;
        end
        req[0] = 1'b0;
        chk("mid_r0_ack", int'(got), 1);
        repeat (3) @(negedge clk);
        bin1 = 8'd142; req[1] = 1'b1;
        vcyc = -1; a1cyc = -1; cyc = 0; got = 0; bcd = '0;
        for (int k = 0; k < 40 && a1cyc < 0; k++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (valid && vcyc < 0) begin vcyc = cyc; bcd = {hundreds, tens, ones}; end
            if (ack[1]) begin a1cyc = cyc; req[1] = 1'b0; end
        end
        req[1] = 1'b0;
        chk("mid_r0_bcd", int'(bcd), 'h037);
        chk("mid_r1_grant_after_done", a1cyc - vcyc, 1);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (valid) begin got = 1; bcd = {hundreds, tens, ones}; rid = int'(id); end
        end
        chk("mid_r1_bcd", int'(bcd), 'h142);
        chk("mid_r1_id", rid, 1);
        repeat (2) @(negedge clk);

        // Reset during the 4th SHIFT cycle of 200
        @(posedge clk); #1;
        bin0 = 8'd200; req = 2'b01;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ack[0]) got = 1;
        end
        req = 2'b00;
        chk("rst_mid_ack", int'(got), 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({ack, busy, valid, id, hundreds, tens, ones}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid) nval++;
        end
        chk("rst_mid_no_valid", nval, 0);
        do_conv(0, 200, bcd, rid, lat);
        chk("rst_mid_reconv", int'(bcd), 'h200);

        // Sweep all 8-bit values on requester 0
        for (int v = 0; v < 256; v++) begin
            do_conv(0, v, bcd, rid, lat);
            chk($sformatf("sweep_%0d", v), int'(bcd), int'(dec3(v)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL global_timeout reached t=%0t want finish earlier", $time);
        $fatal(1, "global timeout");
    end

endmodule
